l1_wb_arb: RTL and testbench
============================

// Module: l1_wb_arb
// PURPOSE
//  Shares one Wishbone B4 pipelined master port between L1I refills and L1D accesses.
//  Round-robin arbitration, one transaction at a time; sequences multi-beat line refills.
//  Collects refill beats into a line buffer and returns one ack pulse per transaction.
// PARAMETERS
//  ADDR_W      32  address width (byte address)
//  DATA_W      32  Wishbone data width; byte-enable width BE_W = DATA_W/8
//  LINE_WORDS  4   DATA_W words per cache line; power of 2, >=2
// PORTS
//  clk          in   1                 clock; single clock domain
//  rst_n        in   1                 asynchronous active-low reset
//  i_req_val    in   1                 L1I refill request; held until i_req_ack
//  i_req_addr   in   ADDR_W            L1I miss address
//  i_req_ack    out  1                 1-cycle completion pulse to L1I
//  i_ack_data   out  LINE_WORDS*DATA_W refill line; word k at bits [k*DATA_W +: DATA_W]
//  d_req_val    in   1                 L1D request; held until d_req_ack
//  d_req_we     in   1                 1 = store (always one beat)
//  d_req_nc     in   1                 1 = non-cacheable load (one beat)
//  d_req_addr   in   ADDR_W            L1D address
//  d_req_wdata  in   DATA_W            store data
//  d_req_be     in   BE_W              byte enables for store / nc load
//  d_req_ack    out  1                 1-cycle completion pulse to L1D
//  d_ack_data   out  LINE_WORDS*DATA_W refill line, or nc word in its slot
//  wb_adr_o     out  ADDR_W            Wishbone address
//  wb_dat_o     out  DATA_W            write data (d_req_wdata on store, else 0)
//  wb_sel_o     out  BE_W              d_req_be for store / nc load; all ones for refill
//  wb_we_o      out  1                 1 on store
//  wb_cyc_o     out  1                 bus cycle active
//  wb_stb_o     out  1                 beat strobe
//  wb_stall_i   in   1                 slave stall; beat not accepted while high
//  wb_ack_i     in   1                 beat ack; ignored when wb_cyc_o = 0
//  wb_dat_i     in   DATA_W            read data, valid with wb_ack_i
//  wb_err_i     in   1                 error; terminates a beat like ack, data word forced 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; last_grant = L1D; line buffers = 0.
//  FSM: IDLE -> ISSUE (grant) -> WAIT (all beats issued) -> RESP (all acked) -> IDLE.
//  IDLE: grant if any val. Both valid: grant the requester not granted last. Latch addr/cop/data.
//  Beats N: L1I, or L1D load with nc=0 -> LINE_WORDS; L1D store, or nc load -> 1.
//  Refill address: line base (addr with low log2(LINE_WORDS*BE_W) bits = 0) + k*BE_W, k = 0..N-1.
//  Single-beat address = d_req_addr unchanged.
//  ISSUE: cyc = stb = 1; issue counter and wb_adr_o advance on stb & !stall; stall holds adr/stb stable.
//  Last beat accepted -> stb drops next cycle; cyc stays 1 until the N-th ack/err.
//  Acks may arrive during ISSUE. Ack counter k writes wb_dat_i into slot k of the granted line buffer.
//  nc load: word written to slot addr[word index]; other slots 0. Store: buffer unchanged.
//  RESP: cyc = 0; requester's ack pulses exactly 1 cycle; ack_data valid then.
//  ack_data holds until that requester's next RESP.
//  Requester drops val the cycle after ack; IDLE re-arbitrates that cycle (no back-to-back grant of stale val).
//  Min latency, 1 beat, zero wait: val @c0, stb @c1, ack_i @c2, req_ack @c3.
//  Ungranted requester waits; its val/addr are not sampled until granted.
//  Reset mid-transaction: cyc/stb drop immediately; transaction discarded; no ack issued.
// TESTING
//  1 Reset mid-refill (beat 2 of 4) -> cyc/stb = 0 at once, no i_req_ack; after release, IDLE, first tie goes to L1I.
//  2 L1I refill 0x1004, LINE_WORDS=4, slave acks 1 cycle after each stb, data 0xA0..0xA3
//    -> adr 0x1000,0x1004,0x1008,0x100C; i_ack_data = {A3,A2,A1,A0}; single i_req_ack.
//  3 L1D store 0x2002, be=0100, wdata=0x00AB0000 -> one beat: we=1, sel=0100, adr=0x2002; d_req_ack @c3.
//  4 i_req_val and d_req_val both high from reset, held -> L1I served first, then L1D; then alternate while both re-request.
//  5 Refill with wb_stall_i high 3 cycles on beat 1 -> adr/stb held; total 4 acks; line correct.
//  6 nc load 0x3008 with wb_err_i on the beat -> d_req_ack pulses; d_ack_data all 0; cyc drops.

Source files
------------

// File: rtl/l1_wb_arb_if.sv
// Wishbone B4 pipelined bus between the L1 arbiter (master) and the memory slave.
interface l1_wb_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   wb_adr_o;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic                wb_we_o;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_stall_i;
    logic                wb_ack_i;
    logic [DATA_W-1:0]   wb_dat_i;
    logic                wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i
    );
endinterface

// File: rtl/l1_wb_arb.sv
// Round-robin arbiter sharing one Wishbone master port between L1I refills and L1D accesses.
// One transaction at a time; refill beats are collected into a line and returned with one ack.
module l1_wb_arb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req_val,
    input  logic [ADDR_W-1:0]            i_req_addr,
    output logic                         i_req_ack,
    output logic [LINE_WORDS*DATA_W-1:0] i_ack_data,
    input  logic                         d_req_val,
    input  logic                         d_req_we,
    input  logic                         d_req_nc,
    input  logic [ADDR_W-1:0]            d_req_addr,
    input  logic [DATA_W-1:0]            d_req_wdata,
    input  logic [DATA_W/8-1:0]          d_req_be,
    output logic                         d_req_ack,
    output logic [LINE_WORDS*DATA_W-1:0] d_ack_data,
    l1_wb_arb_if.master                  wb
);
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LINE_W = LINE_WORDS * DATA_W;
    localparam int unsigned WIDX_W = $clog2(LINE_WORDS);
    localparam int unsigned BOFF_W = $clog2(BE_W);
    localparam int unsigned OFF_W  = WIDX_W + BOFF_W;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_i_q, gnt_i_d;      // current transaction belongs to L1I
    logic                last_i_q, last_i_d;    // most recent grant went to L1I
    logic                we_q, we_d;
    logic                nc_q, nc_d;
    logic [WIDX_W-1:0]   slot_q, slot_d;        // line slot for a non-cacheable word
    logic [WIDX_W-1:0]   last_beat_q, last_beat_d;
    logic [WIDX_W-1:0]   iss_q, iss_d;
    logic [WIDX_W-1:0]   ack_q, ack_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]   i_data_q, i_data_d;
    logic [LINE_W-1:0]   d_data_q, d_data_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [BE_W-1:0]     sel_q, sel_d;
    logic                wbwe_q, wbwe_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;

    logic                take_i;
    logic                refill;
    logic [ADDR_W-1:0]   req_addr;
    logic [WIDX_W-1:0]   wr_slot;
    logic [DATA_W-1:0]   beat_word;
    logic                accept;
    logic                beat_done;

    // Next-state, bus sequencing and line collection
    always_comb begin
        state_d     = state_q;
        gnt_i_d     = gnt_i_q;
        last_i_d    = last_i_q;
        we_d        = we_q;
        nc_d        = nc_q;
        slot_d      = slot_q;
        last_beat_d = last_beat_q;
        iss_d       = iss_q;
        ack_d       = ack_q;
        buf_d       = buf_q;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        wbwe_d      = wbwe_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        take_i      = 1'b0;
        refill      = 1'b0;
        req_addr    = '0;
        wr_slot     = '0;
        beat_word   = '0;
        accept      = stb_q & ~wb.wb_stall_i;
        beat_done   = cyc_q & (wb.wb_ack_i | wb.wb_err_i);

        unique case (state_q)
            IDLE: begin
                if (i_req_val | d_req_val) begin
                    take_i   = i_req_val & (~d_req_val | ~last_i_q);
                    refill   = take_i | (~d_req_we & ~d_req_nc);
                    req_addr = take_i ? i_req_addr : d_req_addr;
                    gnt_i_d  = take_i;
                    last_i_d = take_i;
                    we_d     = ~take_i & d_req_we;
                    nc_d     = ~take_i & ~d_req_we & d_req_nc;
                    slot_d   = d_req_addr[BOFF_W +: WIDX_W];
                    last_beat_d = refill ? WIDX_W'(LINE_WORDS - 1) : '0;
                    adr_d    = refill ? (req_addr & BASE_MASK) : req_addr;
                    dat_d    = (~take_i & d_req_we) ? d_req_wdata : '0;
                    sel_d    = refill ? '1 : d_req_be;
                    wbwe_d   = ~take_i & d_req_we;
                    iss_d    = '0;
                    ack_d    = '0;
                    buf_d    = '0;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (accept) begin
                    if (iss_q == last_beat_q) begin
                        stb_d   = 1'b0;
                        state_d = WAIT;
                    end else begin
                        iss_d = iss_q + WIDX_W'(1);
                        adr_d = adr_q + ADDR_W'(BE_W);
                    end
                end
                // Acks may overlap issue; an error terminates the beat with a zero word
                if (beat_done) begin
                    beat_word = wb.wb_err_i ? '0 : wb.wb_dat_i;
                    wr_slot   = nc_q ? slot_q : ack_q;
                    if (!we_q) begin
                        buf_d[int'(wr_slot)*DATA_W +: DATA_W] = beat_word;
                    end
                    ack_d = ack_q + WIDX_W'(1);
                    if (ack_q == last_beat_q) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        adr_d   = '0;
                        dat_d   = '0;
                        sel_d   = '0;
                        wbwe_d  = 1'b0;
                        state_d = RESP;
                        if (gnt_i_q) begin
                            i_ack_d  = 1'b1;
                            i_data_d = buf_d;
                        end else begin
                            d_ack_d = 1'b1;
                            if (!we_q) begin
                                d_data_d = buf_d;
                            end
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_i_q     <= 1'b0;
            last_i_q    <= 1'b0;
            we_q        <= 1'b0;
            nc_q        <= 1'b0;
            slot_q      <= '0;
            last_beat_q <= '0;
            iss_q       <= '0;
            ack_q       <= '0;
            buf_q       <= '0;
            i_data_q    <= '0;
            d_data_q    <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            wbwe_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_i_q     <= gnt_i_d;
            last_i_q    <= last_i_d;
            we_q        <= we_d;
            nc_q        <= nc_d;
            slot_q      <= slot_d;
            last_beat_q <= last_beat_d;
            iss_q       <= iss_d;
            ack_q       <= ack_d;
            buf_q       <= buf_d;
            i_data_q    <= i_data_d;
            d_data_q    <= d_data_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            wbwe_q      <= wbwe_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = wbwe_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign i_req_ack   = i_ack_q;
    assign d_req_ack   = d_ack_q;
    assign i_ack_data  = i_data_q;
    assign d_ack_data  = d_data_q;
endmodule

// File: tb/tb_l1_wb_arb.sv
// Scoreboard bench for l1_wb_arb: expected beats/responses are queued, monitors pop and compare.
`timescale 1ns/1ps
module tb_l1_wb_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic         is_i;
        logic [127:0] data;
        int           lat;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic          i_req_val, i_req_ack;
    logic [31:0]   i_req_addr;
    logic [127:0]  i_ack_data;
    logic          d_req_val, d_req_we, d_req_nc, d_req_ack;
    logic [31:0]   d_req_addr, d_req_wdata;
    logic [3:0]    d_req_be;
    logic [127:0]  d_ack_data;

    beat_t       exp_beats[$];
    resp_t       exp_resp[$];
    logic [31:0] rdata_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int start_i = 0;
    int start_d = 0;
    logic err_mode = 1'b0;
    int stall_beat = -1;
    int stall_left = 0;
    int beat_num = 0;
    logic acc;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    l1_wb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

    l1_wb_arb #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack), .i_ack_data(i_ack_data),
        .d_req_val(d_req_val), .d_req_we(d_req_we), .d_req_nc(d_req_nc), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ack(d_req_ack), .d_ack_data(d_ack_data),
        .wb(wb)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                             input logic [31:0] dat, input logic [31:0] rdata);
        beat_t b;
        b.adr = adr; b.we = we; b.sel = sel; b.dat = dat;
        exp_beats.push_back(b);
        rdata_q.push_back(rdata);
    endtask

    task automatic push_resp(input logic is_i, input logic [127:0] data, input int lat);
        resp_t r;
        r.is_i = is_i; r.data = data; r.lat = lat;
        exp_resp.push_back(r);
    endtask

    // Full refill from a hand-computed line base, slave returns d0, d0+1, ...
    task automatic push_refill(input logic is_i, input logic [31:0] base, input logic [31:0] d0);
        logic [127:0] line;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            push_beat(base + 32'(4 * k), 1'b0, 4'hF, 32'h0, d0 + 32'(k));
            line[k*32 +: 32] = d0 + 32'(k);
        end
        push_resp(is_i, line, -1);
    endtask

    task automatic do_i(input logic [31:0] a);
        int t;
        i_req_val = 1'b1; i_req_addr = a; start_i = cyc_cnt; t = 0;
        do begin @(negedge clk); t++; end while (!i_req_ack && t < 300);
        if (!i_req_ack) begin
            n_chk++; n_fail++;
            $display("FAIL i_ack_timeout: got no ack expected ack within 300 cycles");
        end
        @(posedge clk); #1;
        i_req_val = 1'b0;
    endtask

    task automatic do_d(input logic [31:0] a, input logic we, input logic nc,
                        input logic [31:0] wdata, input logic [3:0] be);
        int t;
        d_req_val = 1'b1; d_req_addr = a; d_req_we = we; d_req_nc = nc;
        d_req_wdata = wdata; d_req_be = be; start_d = cyc_cnt; t = 0;
        do begin @(negedge clk); t++; end while (!d_req_ack && t < 300);
        if (!d_req_ack) begin
            n_chk++; n_fail++;
            $display("FAIL d_ack_timeout: got no ack expected ack within 300 cycles");
        end
        @(posedge clk); #1;
        d_req_val = 1'b0;
    endtask

    // Slave: acks each accepted beat on the next cycle, optional stall window and error mode
    initial begin
        wb.wb_stall_i = 1'b0; wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            acc = rst_n && wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_stall_i;
            @(posedge clk); #1;
            wb.wb_ack_i = acc && !err_mode;
            wb.wb_err_i = acc && err_mode;
            wb.wb_dat_i = (acc && rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
            if (!wb.wb_cyc_o) beat_num = 0;
            else if (acc) beat_num++;
            if (wb.wb_cyc_o && beat_num == stall_beat && stall_left > 0) begin
                wb.wb_stall_i = 1'b1;
                stall_left--;
            end else begin
                wb.wb_stall_i = 1'b0;
            end
        end
    end

    // Beat monitor
    always @(negedge clk) begin
        beat_t b;
        if (rst_n && wb.wb_cyc_o && wb.wb_stb_o) begin
            if (exp_beats.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_beat: got adr %h expected no beat", wb.wb_adr_o);
            end else if (wb.wb_stall_i) begin
                check("stall_hold_adr", 128'(wb.wb_adr_o), 128'(exp_beats[0].adr));
            end else begin
                b = exp_beats.pop_front();
                check("beat_adr", 128'(wb.wb_adr_o), 128'(b.adr));
                check("beat_we",  128'(wb.wb_we_o),  128'(b.we));
                check("beat_sel", 128'(wb.wb_sel_o), 128'(b.sel));
                check("beat_dat", 128'(wb.wb_dat_o), 128'(b.dat));
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t r;
        int lat;
        if (rst_n && (i_req_ack || d_req_ack)) begin
            check("ack_cyc_low", 128'(wb.wb_cyc_o), 128'(0));
            check("ack_one_hot", 128'(i_req_ack & d_req_ack), 128'(0));
            check("ack_pulse_width", 128'(prev_ack), 128'(0));
            if (exp_resp.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ack: got i=%0b d=%0b expected none", i_req_ack, d_req_ack);
            end else begin
                r = exp_resp.pop_front();
                check("ack_who", 128'(i_req_ack), 128'(r.is_i));
                check("ack_data", r.is_i ? i_ack_data : d_ack_data, r.data);
                lat = r.is_i ? cyc_cnt - start_i : cyc_cnt - start_d;
                if (r.lat >= 0) check("ack_latency", 128'(lat), 128'(r.lat));
            end
        end
        prev_ack = rst_n && (i_req_ack || d_req_ack);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        i_req_val = 0; i_req_addr = 0; d_req_val = 0; d_req_we = 0; d_req_nc = 0;
        d_req_addr = 0; d_req_wdata = 0; d_req_be = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 128'(wb.wb_cyc_o), 0);
        check("rst_stb", 128'(wb.wb_stb_o), 0);
        check("rst_adr", 128'(wb.wb_adr_o), 0);
        check("rst_we",  128'(wb.wb_we_o), 0);
        check("rst_sel", 128'(wb.wb_sel_o), 0);
        check("rst_dat", 128'(wb.wb_dat_o), 0);
        check("rst_i_ack", 128'(i_req_ack), 0);
        check("rst_d_ack", 128'(d_req_ack), 0);
        check("rst_i_data", i_ack_data, 0);
        check("rst_d_data", d_ack_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset while beat 2 of a 4-beat L1I refill is on the bus
        @(posedge clk); #1;
        push_beat(32'h5000, 1'b0, 4'hF, 32'h0, 32'h50);
        push_beat(32'h5004, 1'b0, 4'hF, 32'h0, 32'h51);
        i_req_val = 1'b1; i_req_addr = 32'h5008;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_pre_stb", 128'(wb.wb_stb_o), 1);
        rst_n = 1'b0; i_req_val = 1'b0;
        #1;
        check("midrst_cyc", 128'(wb.wb_cyc_o), 0);
        check("midrst_stb", 128'(wb.wb_stb_o), 0);
        check("midrst_beats_seen", 128'(exp_beats.size()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie from reset goes to L1I, then the two requesters alternate
        push_refill(1'b1, 32'h6000, 32'h60);
        push_refill(1'b0, 32'h2010, 32'hB0);
        push_refill(1'b1, 32'h7000, 32'hC0);
        push_beat(32'h3004, 1'b0, 4'hF, 32'h0, 32'hD1);
        push_resp(1'b0, 128'h00000000_00000000_000000D1_00000000, -1);
        fork
            begin do_i(32'h6004); @(posedge clk); #1; do_i(32'h7000); end
            begin do_d(32'h2010, 1'b0, 1'b0, 32'h0, 4'hF); @(posedge clk); #1;
                  do_d(32'h3004, 1'b0, 1'b1, 32'h0, 4'hF); end
        join

        // L1I refill of 0x1004
        push_refill(1'b1, 32'h1000, 32'hA0);
        do_i(32'h1004);

        // L1D store, minimum latency, d_ack_data keeps the previous nc line
        push_beat(32'h2002, 1'b1, 4'b0100, 32'h00AB0000, 32'hDEADBEEF);
        push_resp(1'b0, 128'h00000000_00000000_000000D1_00000000, 3);
        do_d(32'h2002, 1'b1, 1'b0, 32'h00AB0000, 4'b0100);

        // Refill with beat 1 stalled for three cycles
        stall_beat = 1; stall_left = 3;
        push_refill(1'b1, 32'h4000, 32'hE0);
        do_i(32'h4008);
        stall_beat = -1;

        // nc load terminated by error
        err_mode = 1'b1;
        push_beat(32'h3008, 1'b0, 4'hF, 32'h0, 32'h77);
        push_resp(1'b0, 128'h0, -1);
        do_d(32'h3008, 1'b0, 1'b1, 32'h0, 4'hF);
        err_mode = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("end_cyc_idle", 128'(wb.wb_cyc_o), 0);
        check("beats_drained", 128'(exp_beats.size()), 0);
        check("resps_drained", 128'(exp_resp.size()), 0);
        check("rdata_drained", 128'(rdata_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
